// File: rtl/grant_pkg.sv
// Shared types, default parameters and the index-to-one-hot helper
// for the grant decoder and its timer.
package grant_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_IDX_W    = 2;
  localparam int DEF_MIN_HOLD = 2;
  localparam int DEF_TIMEOUT  = 8;

  // Widest index the helper supports; callers truncate the result to N bits.
  localparam int MAX_IDX_W = 6;
  localparam int MAX_N     = 1 << MAX_IDX_W;

  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/grant_timer.sv
// Grant-cycle counter: cleared while idle, counts grant cycles and
// saturates at TIMEOUT-1, flagging minimum-hold and timeout points.
module grant_timer #(
  parameter int MIN_HOLD = 2,
  parameter int TIMEOUT  = 8,
  parameter int CNT_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic hold_met_o,
  output logic timed_out_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hold_met_o  = (cnt_q >= HOLD_LAST);
  assign timed_out_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/onehot_grant_decoder.sv
// Registered index-to-one-hot grant with done-driven release, minimum
// hold time and forced release after TIMEOUT grant cycles.
module onehot_grant_decoder
  import grant_pkg::*;
#(
  parameter int IDX_W    = DEF_IDX_W,
  parameter int MIN_HOLD = DEF_MIN_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_idx,
  output logic [(2**IDX_W)-1:0] y,
  input  logic [(2**IDX_W)-1:0] done,
  output logic                  busy,
  output logic                  timeout
);

  localparam int N = 2 ** IDX_W;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     y_q, y_d;
  logic             done_seen_q, done_seen_d;
  logic             timeout_q, timeout_d;
  logic             hold_met, timed_out, done_line, rel;

  grant_timer #(
    .MIN_HOLD (MIN_HOLD),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == IDLE),
    .hold_met_o  (hold_met),
    .timed_out_o (timed_out)
  );

  // Only the granted line's done matters; a done before MIN_HOLD is remembered.
  assign done_line = done[idx_q];
  assign rel       = (done_line | done_seen_q) & hold_met;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    y_d         = y_q;
    done_seen_d = done_seen_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        done_seen_d = 1'b0;
        if (in_valid) begin
          idx_d   = in_idx;
          y_d     = N'(onehot(MAX_IDX_W'(in_idx)));
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (done_line) begin
          done_seen_d = 1'b1;
        end
        if (rel) begin
          y_d     = '0;
          state_d = IDLE;
        end else if (timed_out) begin
          y_d       = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      y_q         <= '0;
      done_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      done_seen_q <= done_seen_d;
      timeout_q   <= timeout_d;
    end
  end

  assign y        = y_q;
  assign busy     = (state_q == GRANT);
  assign in_ready = (state_q == IDLE);
  assign timeout  = timeout_q;

endmodule
